// File: rtl/vga_v_tracker.sv
// Vertical VGA tracker: counts rising edges of the horizontal sync into lines and frame phases.
// Optional macro VGA_V_TRACKER_CHECK_EN adds a sticky line-period consistency check on o_err.
module vga_v_tracker #(
  parameter int P_CNT_WIDTH     = 10,
  parameter int P_V_VISIBLE     = 480,
  parameter int P_V_BACK_PORCH  = 33,
  parameter int P_V_SYNC        = 2,
  parameter int P_V_FRONT_PORCH = 10,
  parameter int P_PERIOD_WIDTH  = 12
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_h_sync,
  output logic                   o_v_sync,
  output logic                   o_v_visible,
  output logic [P_CNT_WIDTH-1:0] o_line,
  output logic                   o_frame_start,
  output logic                   o_err
);

  localparam int LP_TOTAL = P_V_VISIBLE + P_V_BACK_PORCH + P_V_SYNC + P_V_FRONT_PORCH;
  localparam logic [P_CNT_WIDTH-1:0] LP_LINE_LAST  = P_CNT_WIDTH'(LP_TOTAL - 1);
  localparam logic [P_CNT_WIDTH-1:0] LP_VIS_LAST   = P_CNT_WIDTH'(P_V_VISIBLE - 1);
  localparam logic [P_CNT_WIDTH-1:0] LP_BACK_LAST  = P_CNT_WIDTH'(P_V_BACK_PORCH - 1);
  localparam logic [P_CNT_WIDTH-1:0] LP_SYNC_LAST  = P_CNT_WIDTH'(P_V_SYNC - 1);
  localparam logic [P_CNT_WIDTH-1:0] LP_FRONT_LAST = P_CNT_WIDTH'(P_V_FRONT_PORCH - 1);

  typedef enum logic [1:0] {
    ST_VISIBLE,
    ST_BACK_PORCH,
    ST_SYNC,
    ST_FRONT_PORCH
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [P_CNT_WIDTH-1:0] r_phase_cnt;
  logic [P_CNT_WIDTH-1:0] r_line;
  logic                   r_hs_prev;
  logic                   r_armed;
  logic                   r_v_sync;
  logic                   r_v_visible;
  logic                   r_frame_start;
  logic                   w_boundary;
  logic                   w_phase_last;

  // r_armed blocks a sync that is already high at reset release from counting.
  assign w_boundary = i_h_sync & ~r_hs_prev & r_armed;

  always_comb begin
    w_phase_last = 1'b0;
    w_state_next = ST_VISIBLE;
    case (r_state)
      ST_VISIBLE: begin
        w_phase_last = (r_phase_cnt == LP_VIS_LAST);
        w_state_next = ST_BACK_PORCH;
      end
      ST_BACK_PORCH: begin
        w_phase_last = (r_phase_cnt == LP_BACK_LAST);
        w_state_next = ST_SYNC;
      end
      ST_SYNC: begin
        w_phase_last = (r_phase_cnt == LP_SYNC_LAST);
        w_state_next = ST_FRONT_PORCH;
      end
      default: begin
        w_phase_last = (r_phase_cnt == LP_FRONT_LAST);
        w_state_next = ST_VISIBLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_VISIBLE;
      r_phase_cnt   <= '0;
      r_line        <= '0;
      r_hs_prev     <= 1'b0;
      r_armed       <= 1'b0;
      r_v_sync      <= 1'b0;
      r_v_visible   <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_hs_prev     <= i_h_sync;
      r_armed       <= r_armed | ~i_h_sync;
      r_frame_start <= 1'b0;
      if (w_boundary) begin
        r_frame_start <= (r_line == LP_LINE_LAST);
        r_line        <= (r_line == LP_LINE_LAST) ? '0 : r_line + P_CNT_WIDTH'(1);
        if (w_phase_last) begin
          r_phase_cnt <= '0;
          r_state     <= w_state_next;
          r_v_sync    <= (w_state_next == ST_SYNC);
          r_v_visible <= (w_state_next == ST_VISIBLE);
        end else begin
          r_phase_cnt <= r_phase_cnt + P_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_v_sync      = r_v_sync;
  assign o_v_visible   = r_v_visible;
  assign o_line        = r_line;
  assign o_frame_start = r_frame_start;

`ifdef VGA_V_TRACKER_CHECK_EN
  logic [P_PERIOD_WIDTH-1:0] r_period;
  logic [P_PERIOD_WIDTH-1:0] r_ref_period;
  logic                      r_started;
  logic                      r_ref_valid;
  logic                      r_err;

  // r_period holds the clocks elapsed since the previous boundary, saturating.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_period     <= '0;
      r_ref_period <= '0;
      r_started    <= 1'b0;
      r_ref_valid  <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_boundary) begin
      r_period <= P_PERIOD_WIDTH'(1);
      if (!r_started) begin
        r_started <= 1'b1;
      end else if (!r_ref_valid) begin
        r_ref_period <= r_period;
        r_ref_valid  <= 1'b1;
      end else if (r_period != r_ref_period) begin
        r_err <= 1'b1;
      end
    end else if (r_period != '1) begin
      r_period <= r_period + P_PERIOD_WIDTH'(1);
    end
  end

  assign o_err = r_err;
`else
  localparam int LP_UNUSED_PERIOD_W = P_PERIOD_WIDTH;
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_v_tracker.sv
// Bench for vga_v_tracker: a small 1/2/3/4 instance and a default-parameter instance share stimulus;
// a line-count model is compared every cycle, and directed checks pin literal values.
module tb_vga_v_tracker;

`ifdef VGA_V_TRACKER_CHECK_EN
  localparam bit EXP_CHECK = 1'b1;
`else
  localparam bit EXP_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs  = 1'b0;

  always #5 clk = ~clk;

  logic       s_vsync, s_vis, s_fs, s_err;
  logic [3:0] s_line;
  logic       d_vsync, d_vis, d_fs, d_err;
  logic [9:0] d_line;

  vga_v_tracker #(
    .P_CNT_WIDTH(4), .P_V_VISIBLE(1), .P_V_BACK_PORCH(2), .P_V_SYNC(3), .P_V_FRONT_PORCH(4),
    .P_PERIOD_WIDTH(12)
  ) dut_small (
    .i_clk(clk), .i_reset(rst), .i_h_sync(hs),
    .o_v_sync(s_vsync), .o_v_visible(s_vis), .o_line(s_line),
    .o_frame_start(s_fs), .o_err(s_err)
  );

  vga_v_tracker dut_def (
    .i_clk(clk), .i_reset(rst), .i_h_sync(hs),
    .o_v_sync(d_vsync), .o_v_visible(d_vis), .o_line(d_line),
    .o_frame_start(d_fs), .o_err(d_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: lines are just a count of qualifying sync rising edges modulo the frame length.
  int m_ls, m_ld, m_cnt, m_ref;
  bit m_prev, m_armed, m_fs_s, m_fs_d, m_started, m_refv, m_err;

  always @(posedge clk or posedge rst) begin : model
    bit bd;
    if (rst) begin
      m_ls = 0; m_ld = 0; m_cnt = 0; m_ref = 0;
      m_prev = 0; m_armed = 0; m_fs_s = 0; m_fs_d = 0;
      m_started = 0; m_refv = 0; m_err = 0;
    end else begin
      bd = hs && !m_prev && m_armed;
      m_armed = m_armed || !hs;
      m_prev = hs;
      m_fs_s = 0;
      m_fs_d = 0;
      if (bd) begin
        m_ls = (m_ls + 1) % 10;
        m_ld = (m_ld + 1) % 525;
        m_fs_s = (m_ls == 0);
        m_fs_d = (m_ld == 0);
        if (!m_started) m_started = 1;
        else if (!m_refv) begin m_ref = m_cnt; m_refv = 1; end
        else if (m_cnt != m_ref) m_err = EXP_CHECK;
        m_cnt = 1;
      end else if (m_cnt < 4095) begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    chk("s_line", int'(s_line), m_ls);
    chk("s_visible", int'(s_vis), int'(m_ls < 1));
    chk("s_vsync", int'(s_vsync), int'(m_ls >= 3 && m_ls < 6));
    chk("s_frame_start", int'(s_fs), int'(m_fs_s));
    chk("s_err", int'(s_err), int'(m_err));
    chk("d_line", int'(d_line), m_ld);
    chk("d_visible", int'(d_vis), int'(m_ld < 480));
    chk("d_vsync", int'(d_vsync), int'(m_ld >= 513 && m_ld < 515));
    chk("d_frame_start", int'(d_fs), int'(m_fs_d));
    chk("d_err", int'(d_err), int'(m_err));
  end

  // Raises sync for one cycle; returns just after the edge that registered the boundary.
  task automatic pulse();
    @(posedge clk); #2 hs = 1'b1;
    @(posedge clk); #2 hs = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int nfs;
    int nsync;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    gap(3);
    chk("rst_line", int'(s_line), 0);
    chk("rst_visible", int'(s_vis), 1);
    chk("rst_vsync", int'(s_vsync), 0);
    chk("rst_frame_start", int'(s_fs), 0);
    chk("rst_err", int'(s_err), 0);

    // Ten boundaries at period 8: lines 1..9 then wrap to 0.
    for (int i = 0; i < 10; i++) begin
      pulse();
      chk("seq_line", int'(s_line), (i + 1) % 10);
      chk("seq_frame_start", int'(s_fs), int'(i == 9));
      chk("seq_vsync", int'(s_vsync), int'(i >= 2 && i <= 4));
      chk("seq_visible", int'(s_vis), int'(i == 9));
      $display("pulse %0d: line=%0d vsync=%0d visible=%0d fs=%0d", i, s_line, s_vsync, s_vis, s_fs);
      gap(6);
    end

    // Period 9 preceding the second boundary below.
    pulse(); chk("per_line1", int'(s_line), 1); chk("per_err_ok", int'(s_err), 0);
    gap(7);
    pulse(); chk("per_line2", int'(s_line), 2); chk("per_err_set", int'(s_err), int'(EXP_CHECK));
    gap(6);
    pulse(); chk("per_err_sticky", int'(s_err), int'(EXP_CHECK));
    gap(6);
    $display("period test: line=%0d err=%0d", s_line, s_err);

    // Sync held high for 5 cycles counts once, then one more pulse.
    @(posedge clk); #2 hs = 1'b1;
    repeat (5) @(posedge clk);
    #2 hs = 1'b0;
    chk("held_line", int'(s_line), 4);
    gap(3);
    pulse(); chk("held_plus_pulse", int'(s_line), 5);
    $display("held-high test: line=%0d", s_line);
    gap(6);

    for (int i = 0; i < 9; i++) begin
      pulse();
      if (i != 8) gap(6);
    end
    chk("pre_reset_line", int'(s_line), 4);

    // Asynchronous reset between edges, with sync high across release.
    #1 rst = 1'b1; hs = 1'b1;
    #1;
    chk("async_line", int'(s_line), 0);
    chk("async_visible", int'(s_vis), 1);
    chk("async_vsync", int'(s_vsync), 0);
    chk("async_frame_start", int'(s_fs), 0);
    chk("async_err", int'(s_err), 0);
    $display("async reset: line=%0d visible=%0d", s_line, s_vis);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    gap(3);
    #2 hs = 1'b0;
    chk("held_at_release_line", int'(s_line), 0);
    gap(2);
    pulse(); chk("resume_line", int'(s_line), 1);
    gap(6);

    // Default geometry for two full frames at period 4.
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    gap(2);
    nfs = 0;
    nsync = 0;
    for (int k = 1; k <= 1050; k++) begin
      pulse();
      if (d_fs) nfs++;
      if (d_vsync) nsync++;
      if (k == 512) chk("def_vsync_512", int'(d_vsync), 0);
      if (k == 513) chk("def_vsync_513", int'(d_vsync), 1);
      if (k == 514) chk("def_vsync_514", int'(d_vsync), 1);
      if (k == 515) chk("def_vsync_515", int'(d_vsync), 0);
      if (k == 525 || k == 1050) begin
        chk("def_wrap_line", int'(d_line), 0);
        chk("def_wrap_fs", int'(d_fs), 1);
        $display("frame end at boundary %0d: line=%0d fs=%0d", k, d_line, d_fs);
      end
      gap(2);
    end
    chk("def_frame_count", nfs, 2);
    chk("def_sync_lines", nsync, 4);
    chk("def_err", int'(d_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
